// File: rtl/param_cpu_pkg.sv
// rtl/param_cpu_pkg.sv - shared types and encodings for param_cpu
package param_cpu_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_MEM2 = 2'd2,
    S_HALT = 2'd3
  } state_t;

  // Opcode byte field positions (bit indices within the 8-bit opcode)
  localparam int OPC_DST_HI  = 7;
  localparam int OPC_DST_LO  = 6;
  localparam int OPC_ALU_BIT = 5;
  localparam int OPC_REG_BIT = 4;
  localparam int OPC_OP_HI   = 3;
  localparam int OPC_OP_LO   = 0;

  // ALU op codes (use_alu = 1); 7..15 are NOP
  localparam logic [3:0] ALU_ADD  = 4'd0;
  localparam logic [3:0] ALU_SUB  = 4'd1;
  localparam logic [3:0] ALU_AND  = 4'd2;
  localparam logic [3:0] ALU_OR   = 4'd3;
  localparam logic [3:0] ALU_XOR  = 4'd4;
  localparam logic [3:0] ALU_SHL1 = 4'd5;
  localparam logic [3:0] ALU_SHR1 = 4'd6;

  // Non-ALU op codes (use_alu = 0); unlisted codes are NOP
  localparam logic [3:0] OP_LOAD  = 4'd1;
  localparam logic [3:0] OP_STORE = 4'd2;
  localparam logic [3:0] OP_CMP   = 4'd3;
  localparam logic [3:0] OP_HALT  = 4'd4;
  localparam logic [3:0] OP_JMP   = 4'd5;
  localparam logic [3:0] OP_JZ    = 4'd6;
  localparam logic [3:0] OP_JNZ   = 4'd7;
  localparam logic [3:0] OP_MOV   = 4'd8;
  localparam logic [3:0] OP_JC    = 4'd9;
  localparam logic [3:0] OP_CALL  = 4'd10;
  localparam logic [3:0] OP_RET   = 4'd11;

endpackage

// File: rtl/param_cpu_alu.sv
// rtl/param_cpu_alu.sv - combinational ALU (module param_alu) for param_cpu
module param_alu
  import param_cpu_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic [3:0]        op,
  output logic [DATA_W-1:0] result,
  output logic              carry
);

  // Result and carry/borrow/shifted-out bit; NOP codes pass a through
  always_comb begin
    result = a;
    carry  = 1'b0;
    case (op)
      ALU_ADD:  {carry, result} = {1'b0, a} + {1'b0, b};
      ALU_SUB:  {carry, result} = {1'b0, a} - {1'b0, b};
      ALU_AND:  result = a & b;
      ALU_OR:   result = a | b;
      ALU_XOR:  result = a ^ b;
      ALU_SHL1: begin
        result = {a[DATA_W-2:0], 1'b0};
        carry  = a[DATA_W-1];
      end
      ALU_SHR1: begin
        result = {1'b0, a[DATA_W-1:1]};
        carry  = a[0];
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/param_cpu.sv
// rtl/param_cpu.sv - small parameterised CPU; CALL/RET stack built only with CPU_STACK_EN
module param_cpu
  import param_cpu_pkg::*;
#(
  parameter int DATA_W      = 8,
  parameter int MEM_WORDS   = 32,
  parameter int STACK_DEPTH = 4,
  localparam int AW = $clog2(MEM_WORDS),
  localparam int IW = 8 + DATA_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              run,
  input  logic              prog_we,
  input  logic [AW-1:0]     prog_addr,
  input  logic [IW-1:0]     prog_wdata,
  input  logic [1:0]        dbg_sel,
  output logic [DATA_W-1:0] dbg_data,
  output logic [AW-1:0]     pc_o,
  output logic              zero_o,
  output logic              carry_o,
  output logic              halted,
  output logic              fault
);

  logic [IW-1:0]     mem [MEM_WORDS];
  logic [DATA_W-1:0] regs [4];
  state_t            state, state_nx;
  logic [AW-1:0]     pc, pc_nx, pc_inc, target, mem_addr;
  logic              z_q, c_q, z_nx, c_nx;

  logic [IW-1:0]     instr;
  logic [7:0]        opc;
  logic [DATA_W-1:0] operand, rd_val, op2, alu_res;
  logic [1:0]        dst;
  logic [3:0]        op;
  logic              use_alu, use_reg, alu_c;

  logic              reg_we, flag_we, mem_we, is_mem, is_halt, fault_set;
  logic [DATA_W-1:0] reg_wd;

  // Decode the word at pc; pc is stable across RUN->MEM2 so MEM2 re-decodes it
  assign instr    = mem[pc];
  assign opc      = instr[IW-1:DATA_W];
  assign operand  = instr[DATA_W-1:0];
  assign dst      = opc[OPC_DST_HI:OPC_DST_LO];
  assign use_alu  = opc[OPC_ALU_BIT];
  assign use_reg  = opc[OPC_REG_BIT];
  assign op       = opc[OPC_OP_HI:OPC_OP_LO];
  assign rd_val   = regs[dst];
  assign op2      = use_reg ? regs[operand[1:0]] : operand;
  assign target   = operand[AW-1:0];
  assign mem_addr = AW'(32'(operand) % MEM_WORDS);
  assign pc_inc   = (pc == AW'(MEM_WORDS - 1)) ? '0 : pc + 1'b1;

  param_alu #(.DATA_W(DATA_W)) u_alu (
    .a      (rd_val),
    .b      (op2),
    .op     (op),
    .result (alu_res),
    .carry  (alu_c)
  );

`ifdef CPU_STACK_EN
  localparam int SPW = $clog2(STACK_DEPTH + 1);
  localparam int SW  = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

  logic [AW-1:0]  stk [STACK_DEPTH];
  logic [SPW-1:0] sp;
  logic           push, pop, stk_full, stk_empty, fault_q;
  logic [AW-1:0]  stk_top;

  assign stk_full  = (sp == SPW'(STACK_DEPTH));
  assign stk_empty = (sp == '0);
  assign stk_top   = stk[SW'(sp - 1'b1)];
  assign fault     = fault_q;

  // Stack pointer moves on CALL/RET that did not fault
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sp <= '0;
    else if (push) sp <= sp + 1'b1;
    else if (pop) sp <= sp - 1'b1;
  end

  // Return-address storage, written at the current top on CALL
  always_ff @(posedge clk) begin
    if (push) stk[SW'(sp)] <= pc_inc;
  end

  // Fault latches on stack over/underflow, cleared when HALT drops back to IDLE
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) fault_q <= 1'b0;
    else if (fault_set) fault_q <= 1'b1;
    else if (state == S_HALT && !run) fault_q <= 1'b0;
  end
`else
  assign fault = 1'b0;
`endif

  // Execute: work out register, flag, memory and pc effects of this cycle
  always_comb begin
    pc_nx     = pc;
    reg_we    = 1'b0;
    reg_wd    = '0;
    flag_we   = 1'b0;
    z_nx      = z_q;
    c_nx      = c_q;
    mem_we    = 1'b0;
    is_mem    = 1'b0;
    is_halt   = 1'b0;
    fault_set = 1'b0;
`ifdef CPU_STACK_EN
    push      = 1'b0;
    pop       = 1'b0;
`endif
    if (state == S_RUN) begin
      pc_nx = pc_inc;
      if (use_alu) begin
        if (op <= ALU_SHR1) begin
          reg_we  = 1'b1;
          reg_wd  = alu_res;
          flag_we = 1'b1;
          z_nx    = (alu_res == '0);
          c_nx    = alu_c;
        end
      end else begin
        case (op)
          OP_LOAD, OP_STORE: begin
            is_mem = 1'b1;
            pc_nx  = pc;
          end
          OP_CMP: begin
            flag_we = 1'b1;
            z_nx    = (rd_val == op2);
            c_nx    = (rd_val < op2);
          end
          OP_HALT: begin
            is_halt = 1'b1;
            pc_nx   = pc;
          end
          OP_JMP: pc_nx = target;
          OP_JZ:  if (z_q) pc_nx = target;
          OP_JNZ: if (!z_q) pc_nx = target;
          OP_JC:  if (c_q) pc_nx = target;
          OP_MOV: begin
            reg_we = 1'b1;
            reg_wd = op2;
          end
`ifdef CPU_STACK_EN
          OP_CALL: begin
            if (stk_full) begin
              fault_set = 1'b1;
              pc_nx     = pc;
            end else begin
              push  = 1'b1;
              pc_nx = target;
            end
          end
          OP_RET: begin
            if (stk_empty) begin
              fault_set = 1'b1;
              pc_nx     = pc;
            end else begin
              pop   = 1'b1;
              pc_nx = stk_top;
            end
          end
`endif
          default: ;
        endcase
      end
    end else if (state == S_MEM2) begin
      pc_nx = pc_inc;
      if (op == OP_LOAD) begin
        reg_we = 1'b1;
        reg_wd = mem[mem_addr][DATA_W-1:0];
      end else begin
        mem_we = 1'b1;
      end
    end
  end

  // FSM next state; an in-flight instruction always completes before IDLE
  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE: if (run) state_nx = S_RUN;
      S_RUN: begin
        if (is_halt || fault_set) state_nx = S_HALT;
        else if (is_mem) state_nx = S_MEM2;
        else if (!run) state_nx = S_IDLE;
      end
      S_MEM2: state_nx = run ? S_RUN : S_IDLE;
      S_HALT: if (!run) state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  // FSM outputs
  always_comb begin
    halted = (state == S_HALT);
  end

  // State and pc; leaving HALT rewinds pc to 0
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
      pc    <= '0;
    end else begin
      state <= state_nx;
      pc    <= (state == S_HALT && !run) ? '0 : pc_nx;
    end
  end

  // Register file and flags
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 4; i++) regs[i] <= '0;
      z_q <= 1'b0;
      c_q <= 1'b0;
    end else begin
      if (reg_we) regs[dst] <= reg_wd;
      if (flag_we) begin
        z_q <= z_nx;
        c_q <= c_nx;
      end
    end
  end

  // Unified memory: STORE keeps the target word's opcode byte; host loads only while stopped
  always_ff @(posedge clk) begin
    if (mem_we) mem[mem_addr] <= {mem[mem_addr][IW-1:DATA_W], rd_val};
    else if (prog_we && (state == S_IDLE || state == S_HALT)) mem[prog_addr] <= prog_wdata;
  end

  assign dbg_data = regs[dbg_sel];
  assign pc_o     = pc;
  assign zero_o   = z_q;
  assign carry_o  = c_q;

endmodule

// File: tb/tb_param_cpu.sv
// tb/tb_param_cpu.sv - self-checking bench for param_cpu (DATA_W=8, MEM_WORDS=16, STACK_DEPTH=2)
module tb_param_cpu;

  localparam int DW = 8;
  localparam int MW = 16;
  localparam int AW = 4;

  localparam int N_NOP = 0, N_LOAD = 1, N_STORE = 2, N_CMP = 3, N_HALT = 4, N_JMP = 5;
  localparam int N_JZ = 6, N_MOV = 8, N_CALL = 10, N_RET = 11;
  localparam int A_ADD = 0, A_SUB = 1, A_OR = 3, A_XOR = 4, A_SHL = 5, A_SHR = 6;

  typedef struct {
    logic [31:0] r0, r1, r2, r3;
    logic [31:0] z, c, f, pc, cyc;
  } exp_t;

  logic          clk = 1'b0, rst_n = 1'b0, run = 1'b0, prog_we = 1'b0;
  logic [AW-1:0] prog_addr = '0;
  logic [DW+7:0] prog_wdata = '0;
  logic [1:0]    dbg_sel = '0;
  logic [DW-1:0] dbg_data;
  logic [AW-1:0] pc_o;
  logic          zero_o, carry_o, halted, fault;

  int   checks = 0;
  int   errors = 0;
  exp_t sb[$];

  always #5 clk = ~clk;

  param_cpu #(.DATA_W(DW), .MEM_WORDS(MW), .STACK_DEPTH(2)) dut (
    .clk(clk), .rst_n(rst_n), .run(run), .prog_we(prog_we), .prog_addr(prog_addr),
    .prog_wdata(prog_wdata), .dbg_sel(dbg_sel), .dbg_data(dbg_data), .pc_o(pc_o),
    .zero_o(zero_o), .carry_o(carry_o), .halted(halted), .fault(fault)
  );

  function automatic logic [15:0] enc(int rd, int alu, int ureg, int op, int opd);
    return {rd[1:0], alu[0], ureg[0], op[3:0], opd[7:0]};
  endfunction

  task automatic wr(input int a, input logic [15:0] d);
    @(negedge clk);
    prog_we = 1'b1; prog_addr = a[AW-1:0]; prog_wdata = d;
    @(negedge clk);
    prog_we = 1'b0;
  endtask

  task automatic do_reset;
    @(negedge clk);
    run = 1'b0; rst_n = 1'b0;
    #2 rst_n = 1'b1;
  endtask

  task automatic rd(input int s, output logic [31:0] v);
    dbg_sel = s[1:0];
    #1 v = 32'(dbg_data);
  endtask

  task automatic run_prog(input int max, output int cyc);
    cyc = 0;
    @(negedge clk);
    run = 1'b1;
    while (cyc < max && halted !== 1'b1) begin
      @(posedge clk);
      #1 cyc++;
    end
    checks++;
    if (halted !== 1'b1) begin
      errors++;
      $display("FAIL run_timeout halted=%b required 1 after %0d cycles", halted, cyc);
    end
  endtask

  task automatic test_reset;
    logic [31:0] v;
    int cyc;
    do_reset;
    wr(0, enc(1, 0, 0, N_MOV, 9));
    wr(1, enc(1, 1, 0, A_SUB, 9));
    wr(2, enc(0, 0, 0, N_HALT, 0));
    run_prog(20, cyc);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    rd(1, v);
    checks++; if (v !== 32'd0) begin errors++; $display("FAIL rst_r1 got %0h want 0", v); end
    checks++; if (pc_o !== 4'd0) begin errors++; $display("FAIL rst_pc got %0d want 0", pc_o); end
    checks++; if ({halted, fault, zero_o, carry_o} !== 4'b0000) begin
      errors++; $display("FAIL rst_status got %b want 0000", {halted, fault, zero_o, carry_o});
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1 rd(1, v);
    checks++; if (v !== 32'd0 || pc_o !== 4'd0) begin
      errors++; $display("FAIL rst_release_noexec r1=%0h pc=%0d want r1=0 pc=0", v, pc_o);
    end
    @(posedge clk);
    #1 rd(1, v);
    checks++; if (v !== 32'd9) begin errors++; $display("FAIL rst_first_instr got %0h want 9", v); end
  endtask

  task automatic test_add;
    exp_t e, g;
    logic [31:0] v;
    int cyc;
    do_reset;
    wr(0, enc(0, 0, 0, N_MOV, 200));
    wr(1, enc(0, 1, 0, A_ADD, 100));
    wr(2, enc(0, 0, 0, N_HALT, 0));
    e = '{r0: 44, r1: 0, r2: 0, r3: 0, z: 0, c: 1, f: 0, pc: 2, cyc: 4};
    sb.push_back(e);
    run_prog(20, cyc);
    g = sb.pop_front();
    rd(0, v);
    checks++; if (v !== g.r0) begin errors++; $display("FAIL add_r0 got %0d want %0d", v, g.r0); end
    checks++; if (32'(carry_o) !== g.c || 32'(zero_o) !== g.z) begin
      errors++; $display("FAIL add_flags got z=%b c=%b want z=%0d c=%0d", zero_o, carry_o, g.z, g.c);
    end
    checks++; if (32'(pc_o) !== g.pc) begin errors++; $display("FAIL add_pc got %0d want %0d", pc_o, g.pc); end
    checks++; if (cyc !== g.cyc) begin errors++; $display("FAIL add_cycles got %0d want %0d", cyc, g.cyc); end
  endtask

  task automatic test_cmp_jz;
    exp_t e, g;
    logic [31:0] v;
    int cyc;
    do_reset;
    wr(0, enc(1, 0, 0, N_MOV, 5));
    wr(1, enc(1, 0, 0, N_CMP, 5));
    wr(2, enc(0, 0, 0, N_JZ, 6));
    wr(3, enc(0, 0, 0, N_HALT, 0));
    wr(6, enc(0, 0, 0, N_HALT, 0));
    e = '{r0: 0, r1: 5, r2: 0, r3: 0, z: 1, c: 0, f: 0, pc: 6, cyc: 5};
    sb.push_back(e);
    run_prog(20, cyc);
    g = sb.pop_front();
    rd(1, v);
    checks++; if (32'(pc_o) !== g.pc) begin errors++; $display("FAIL jz_pc got %0d want %0d", pc_o, g.pc); end
    checks++; if (32'(zero_o) !== g.z || 32'(carry_o) !== g.c) begin
      errors++; $display("FAIL jz_flags got z=%b c=%b want z=%0d c=%0d", zero_o, carry_o, g.z, g.c);
    end
    checks++; if (v !== g.r1) begin errors++; $display("FAIL jz_r1 got %0d want %0d", v, g.r1); end
    checks++; if (cyc !== g.cyc) begin errors++; $display("FAIL jz_cycles got %0d want %0d", cyc, g.cyc); end
  endtask

  task automatic test_alu_ops;
    exp_t e, g;
    logic [31:0] v0, v1, v2, v3;
    int cyc;
    do_reset;
    wr(0, enc(0, 0, 0, N_MOV, 3));
    wr(1, enc(0, 1, 0, A_SUB, 5));
    wr(2, enc(1, 0, 0, N_MOV, 8'h81));
    wr(3, enc(1, 1, 0, A_SHL, 0));
    wr(4, enc(1, 1, 0, A_SHR, 0));
    wr(5, enc(1, 1, 0, A_XOR, 8'h03));
    wr(6, enc(1, 1, 0, A_OR, 8'h30));
    wr(7, enc(3, 0, 0, N_MOV, 8'hFF));
    wr(8, enc(3, 1, 0, A_ADD, 1));
    wr(9, enc(2, 0, 1, N_MOV, 1));
    wr(10, enc(2, 1, 0, 9, 0));
    wr(11, enc(0, 0, 0, N_HALT, 0));
    e = '{r0: 8'hFE, r1: 8'h32, r2: 8'h32, r3: 0, z: 1, c: 1, f: 0, pc: 11, cyc: 13};
    sb.push_back(e);
    run_prog(40, cyc);
    g = sb.pop_front();
    rd(0, v0); rd(1, v1); rd(2, v2); rd(3, v3);
    checks++; if (v0 !== g.r0) begin errors++; $display("FAIL alu_sub got %0h want %0h", v0, g.r0); end
    checks++; if (v1 !== g.r1) begin errors++; $display("FAIL alu_shift_logic got %0h want %0h", v1, g.r1); end
    checks++; if (v2 !== g.r2) begin errors++; $display("FAIL alu_movreg_nop got %0h want %0h", v2, g.r2); end
    checks++; if (v3 !== g.r3) begin errors++; $display("FAIL alu_add_wrap got %0h want %0h", v3, g.r3); end
    checks++; if (32'(zero_o) !== g.z || 32'(carry_o) !== g.c) begin
      errors++; $display("FAIL alu_flags_kept got z=%b c=%b want z=%0d c=%0d", zero_o, carry_o, g.z, g.c);
    end
    checks++; if (cyc !== g.cyc) begin errors++; $display("FAIL alu_cycles got %0d want %0d", cyc, g.cyc); end
  endtask

  task automatic test_mem;
    exp_t e, g;
    logic [31:0] v;
    int cyc;
    do_reset;
    wr(0, enc(0, 0, 0, N_MOV, 7));
    wr(1, enc(0, 0, 0, N_STORE, 20));
    wr(2, enc(2, 0, 0, N_LOAD, 20));
    wr(3, enc(0, 0, 0, N_HALT, 0));
    wr(4, 16'hA500);
    e = '{r0: 7, r1: 0, r2: 7, r3: 0, z: 0, c: 0, f: 0, pc: 3, cyc: 7};
    sb.push_back(e);
    run_prog(20, cyc);
    g = sb.pop_front();
    rd(2, v);
    checks++; if (v !== g.r2) begin errors++; $display("FAIL mem_load got %0d want %0d", v, g.r2); end
    checks++; if (dut.mem[4] !== 16'hA507) begin errors++; $display("FAIL mem_word got %h want a507", dut.mem[4]); end
    checks++; if (cyc !== g.cyc) begin errors++; $display("FAIL mem_cycles got %0d want %0d", cyc, g.cyc); end
  endtask

  task automatic test_back_to_back;
    exp_t e, g;
    logic [31:0] v;
    int cyc;
    do_reset;
    wr(0, enc(3, 0, 0, N_LOAD, 12));
    wr(1, enc(3, 0, 0, N_STORE, 13));
    wr(2, enc(0, 0, 0, N_LOAD, 13));
    wr(3, enc(0, 0, 0, N_HALT, 0));
    wr(12, 16'h105C);
    wr(13, 16'h7700);
    e = '{r0: 8'h5C, r1: 0, r2: 0, r3: 8'h5C, z: 0, c: 0, f: 0, pc: 3, cyc: 8};
    sb.push_back(e);
    run_prog(20, cyc);
    g = sb.pop_front();
    rd(0, v);
    checks++; if (v !== g.r0) begin errors++; $display("FAIL b2b_r0 got %0h want %0h", v, g.r0); end
    checks++; if (dut.mem[13] !== 16'h775C) begin errors++; $display("FAIL b2b_store got %h want 775c", dut.mem[13]); end
    checks++; if (cyc !== g.cyc) begin errors++; $display("FAIL b2b_cycles got %0d want %0d", cyc, g.cyc); end
  endtask

  task automatic test_wrap;
    exp_t e, g;
    int cyc;
    do_reset;
    wr(0, enc(0, 0, 0, N_JZ, 3));
    wr(1, enc(0, 0, 0, N_CMP, 0));
    wr(2, enc(0, 0, 0, N_JMP, 15));
    wr(3, enc(0, 0, 0, N_HALT, 0));
    wr(15, enc(0, 0, 0, N_NOP, 0));
    e = '{r0: 0, r1: 0, r2: 0, r3: 0, z: 1, c: 0, f: 0, pc: 3, cyc: 7};
    sb.push_back(e);
    run_prog(20, cyc);
    g = sb.pop_front();
    checks++; if (32'(pc_o) !== g.pc || 32'(fault) !== g.f) begin
      errors++; $display("FAIL wrap_pc got pc=%0d fault=%b want pc=%0d fault=%0d", pc_o, fault, g.pc, g.f);
    end
    checks++; if (cyc !== g.cyc) begin errors++; $display("FAIL wrap_cycles got %0d want %0d", cyc, g.cyc); end
  endtask

  task automatic test_stack;
    exp_t e, g;
    logic [31:0] v;
    int cyc;
    do_reset;
    wr(0, enc(0, 0, 0, N_CALL, 4));
    wr(1, enc(0, 0, 0, N_HALT, 0));
    wr(4, enc(3, 0, 0, N_MOV, 8'h42));
    wr(5, enc(0, 0, 0, N_RET, 0));
`ifdef CPU_STACK_EN
    e = '{r0: 0, r1: 0, r2: 0, r3: 8'h42, z: 0, c: 0, f: 0, pc: 1, cyc: 5};
`else
    e = '{r0: 0, r1: 0, r2: 0, r3: 0, z: 0, c: 0, f: 0, pc: 1, cyc: 3};
`endif
    sb.push_back(e);
    run_prog(20, cyc);
    g = sb.pop_front();
    rd(3, v);
    checks++; if (v !== g.r3 || 32'(pc_o) !== g.pc || 32'(fault) !== g.f) begin
      errors++; $display("FAIL call_ret got r3=%0h pc=%0d fault=%b want r3=%0h pc=%0d fault=%0d", v, pc_o, fault, g.r3, g.pc, g.f);
    end
    checks++; if (cyc !== g.cyc) begin errors++; $display("FAIL call_ret_cycles got %0d want %0d", cyc, g.cyc); end
`ifdef CPU_STACK_EN
    do_reset;
    wr(0, enc(0, 0, 0, N_JMP, 2));
    wr(2, enc(0, 0, 0, N_CALL, 2));
    e = '{r0: 0, r1: 0, r2: 0, r3: 0, z: 0, c: 0, f: 1, pc: 2, cyc: 5};
    sb.push_back(e);
    run_prog(20, cyc);
    g = sb.pop_front();
    checks++; if (32'(fault) !== g.f || 32'(pc_o) !== g.pc) begin
      errors++; $display("FAIL stack_overflow got fault=%b pc=%0d want fault=%0d pc=%0d", fault, pc_o, g.f, g.pc);
    end
    checks++; if (cyc !== g.cyc) begin errors++; $display("FAIL overflow_cycles got %0d want %0d", cyc, g.cyc); end
    @(negedge clk);
    run = 1'b0;
    @(posedge clk);
    #1;
    checks++; if ({fault, halted} !== 2'b00 || pc_o !== 4'd0) begin
      errors++; $display("FAIL halt_exit got fault=%b halted=%b pc=%0d want 0 0 0", fault, halted, pc_o);
    end
    do_reset;
    wr(0, enc(0, 0, 0, N_RET, 0));
    run_prog(20, cyc);
    checks++; if (fault !== 1'b1 || pc_o !== 4'd0 || cyc !== 2) begin
      errors++; $display("FAIL stack_underflow got fault=%b pc=%0d cyc=%0d want 1 0 2", fault, pc_o, cyc);
    end
`else
    checks++; if (fault !== 1'b0) begin errors++; $display("FAIL no_stack_fault got %b want 0", fault); end
`endif
  endtask

  task automatic test_reset_mem2;
    logic [31:0] v;
    do_reset;
    wr(0, enc(2, 0, 0, N_MOV, 8'h11));
    wr(1, enc(2, 0, 0, N_LOAD, 12));
    wr(12, 16'h105C);
    @(negedge clk);
    run = 1'b1;
    repeat (3) @(posedge clk);
    #1 rd(2, v);
    checks++; if (v !== 32'h11 || pc_o !== 4'd1) begin
      errors++; $display("FAIL mem2_entry got r2=%0h pc=%0d want r2=11 pc=1", v, pc_o);
    end
    rst_n = 1'b0;
    #1 rd(2, v);
    checks++; if (v !== 32'd0 || pc_o !== 4'd0 || halted !== 1'b0) begin
      errors++; $display("FAIL mem2_reset got r2=%0h pc=%0d halted=%b want 0 0 0", v, pc_o, halted);
    end
    run = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1 rd(2, v);
    checks++; if (v !== 32'd0 || pc_o !== 4'd0) begin
      errors++; $display("FAIL mem2_idle got r2=%0h pc=%0d want 0 0", v, pc_o);
    end
  endtask

  task automatic test_pause_resume;
    logic [31:0] v;
    do_reset;
    wr(0, enc(0, 0, 0, N_MOV, 1));
    wr(1, enc(0, 1, 0, A_ADD, 1));
    wr(2, enc(0, 0, 0, N_JMP, 1));
    wr(12, 16'h105C);
    @(negedge clk);
    run = 1'b1;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    prog_we = 1'b1; prog_addr = 4'd12; prog_wdata = 16'hFFFF;
    @(posedge clk);
    @(negedge clk);
    prog_we = 1'b0;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    run = 1'b0;
    @(posedge clk);
    repeat (2) @(posedge clk);
    #1 rd(0, v);
    checks++; if (v !== 32'd3 || pc_o !== 4'd1 || halted !== 1'b0) begin
      errors++; $display("FAIL pause got r0=%0d pc=%0d halted=%b want 3 1 0", v, pc_o, halted);
    end
    checks++; if (dut.mem[12] !== 16'h105C) begin
      errors++; $display("FAIL prog_we_in_run got %h want 105c", dut.mem[12]);
    end
    @(negedge clk);
    run = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1 rd(0, v);
    checks++; if (v !== 32'd4 || pc_o !== 4'd2) begin
      errors++; $display("FAIL resume got r0=%0d pc=%0d want 4 2", v, pc_o);
    end
    @(negedge clk);
    run = 1'b0;
  endtask

  initial begin
    test_reset;
    test_add;
    test_cmp_jz;
    test_alu_ops;
    test_mem;
    test_back_to_back;
    test_wrap;
    test_stack;
    test_reset_mem2;
    test_pause_resume;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/param_cpu.md
PARAM_CPU -- requirements
Module: param_cpu

Interface
REQ-001 Parameter DATA_W, default 8: register/operand width in bits, legal range 8..32.
REQ-002 Parameter MEM_WORDS, default 32: unified program/data memory depth in words; each word is 8+DATA_W bits, legal range 4..256.
REQ-003 Parameter STACK_DEPTH, default 4: return-address stack entries; only meaningful when CPU_STACK_EN is defined.
REQ-004 The block SHALL have one clock, clk, and an asynchronous, active-low reset, rst_n.
REQ-005 Ports, in order:
- clk  in  1  clock.
- rst_n  in  1  async active-low reset.
- run  in  1  start/continue execution.
- prog_we  in  1  program write strobe.
- prog_addr  in  AW=$clog2(MEM_WORDS)  write address.
- prog_wdata  in  8+DATA_W  instruction word.
- dbg_sel  in  2  register select.
- dbg_data  out  DATA_W  registers[dbg_sel], combinational.
- pc_o  out  AW  current pc.
- zero_o  out  1  Z flag.
- carry_o  out  1  C flag.
- halted  out  1  HALT state.
- fault  out  1  stack fault latched.

Function
REQ-006 Instruction word: opcode = [DATA_W+7:DATA_W], operand = [DATA_W-1:0]. Opcode bits [7:6] = dest register, [5] = use_alu, [4] = use_reg, [3:0] = op. If use_reg=1, op2 = registers[operand[1:0]]; otherwise op2 = operand.
REQ-007 FSM states: IDLE, RUN, MEM2, HALT. Transitions:
- IDLE -> RUN when run=1.
- RUN -> MEM2 on LOAD/STORE.
- MEM2 -> RUN after one cycle.
- RUN -> HALT on HALT or fault.
- HALT -> IDLE when run=0; pc and fault clear on this transition.
- RUN or MEM2 with run=0: finish the current instruction, then go to IDLE; pc is kept, so the next run=1 resumes.
REQ-008 prog_we writes mem[prog_addr] only in IDLE or HALT; it is ignored in RUN and MEM2.
REQ-009 ALU ops (use_alu=1), 1 cycle: ADD, SUB, AND, OR, XOR, SHL1, SHR1 on Rd and op2, result truncated to DATA_W. Flags:
- Z = (result == 0).
- C = carry-out for ADD; borrow for SUB; bit shifted out for shifts; 0 for logic ops.
- Op codes 7..15 act as NOP.
REQ-010 Non-ALU op codes (use_alu=0), each 1 cycle unless stated:
- 1 LOAD: Rd <= mem[operand mod MEM_WORDS][DATA_W-1:0]; 2 cycles; pc increments in MEM2.
- 2 STORE: low DATA_W bits of the word <= Rd, opcode byte preserved; 2 cycles.
- 3 CMP: Z = (Rd == op2), C = (Rd < op2) unsigned.
- 4 HALT.
- 5 JMP.
- 6 JZ.
- 7 JNZ.
- 8 MOV: Rd <= op2.
- 9 JC.
- 10 CALL.
- 11 RET.
- All other codes: NOP.
REQ-011 Jump targets = operand[AW-1:0]. A jump that is not taken increments pc.
REQ-012 Flags change only on ALU ops and CMP; all other instructions preserve Z and C.
REQ-013 pc+1 SHALL wrap from MEM_WORDS-1 to 0 with no fault.
REQ-014 CALL pushes pc+1 and jumps. RET pops into pc.
- CALL with the stack full, or RET with it empty: no push/pop, fault=1, go to HALT.
REQ-015 A load to register Rd, with a STORE of Rd in the next instruction, SHALL store the newly loaded value.

Reset
REQ-016 Asynchronous assertion of rst_n=0 SHALL force, in any state including MEM2:
- state = IDLE, pc = 0.
- all four registers = 0.
- Z = 0, C = 0, halted = 0, fault = 0.
- stack pointer = 0.
- Memory contents are unchanged.
REQ-017 Release of rst_n SHALL take effect on the first clk rising edge after deassertion; no instruction executes in that cycle.

Configuration
REQ-018 Macro CPU_STACK_EN:
- Defined: CALL/RET and the stack exist as specified.
- Undefined: op codes 10/11 act as NOP, no stack storage is built, and fault is tied to 0.

Structure
REQ-019 Shared package param_cpu_pkg SHALL hold:
- the state enum;
- the op-code constants for ALU and non-ALU ops;
- the opcode field-position constants.
REQ-020 The ALU SHALL be a sub-module, param_alu, parametrised by DATA_W, purely combinational, producing result and carry.

Verification
REQ-021 DATA_W=8: MOV A,#200; ADD A,#100; HALT -> A=44, C=1, Z=0, halted=1 after 3 run cycles.
REQ-022 MOV B,#5; CMP B,#5; JZ 6 (target holds HALT) -> pc_o=6 and halted=1; Z stays 1 through the JZ.
REQ-023 MOV A,#7; STORE A,20; LOAD C,20 -> C=7, mem[20] opcode byte unchanged, 7 cycles total.
REQ-024 With CPU_STACK_EN and STACK_DEPTH=2, a routine that CALLs itself -> third CALL sets fault=1 and halted=1, with pc held at the CALL address.
REQ-025 Assert rst_n=0 during a LOAD's MEM2 cycle -> destination register=0, pc=0, state IDLE; prog_we during RUN leaves memory unchanged.
REQ-026 MEM_WORDS=16: NOP at address 15 -> pc wraps to 0.
